// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter slice:
//   - arb_state_e : arbiter FSM states, fixed 2-bit encoding
//                   (IDLE=0, LOAD=1, WAIT=2, HOLD=3) so debug taps and
//                   waveforms read the same across builds.
//   - DBIT_DEFAULT: default character width, shared with uart_tx / uart_rx.
//   - HOLD_CNT_W  : width of the hold-timeout counter (HOLD_MAX <= 255).
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  localparam int DBIT_DEFAULT = 8;
  localparam int HOLD_CNT_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester byte streams and the uart_tx control pins.
//
//   Handshake: requester i offers a byte by raising req_valid[i] with
//   req_data slice i and req_last[i] stable; the byte is taken in the cycle
//   where req_valid[i] and req_ready[i] are both high. Once raised, valid and
//   data stay put until accepted. req_ready is one-hot or zero.
//
//   master : the arbiter (drives req_ready and the uart_tx controls)
//   slave  : requesters + uart_tx (drive valids, data, last, done tick)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DBIT  = DBIT_DEFAULT,
  parameter int IDX_W = 3
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;
  logic [IDX_W-1:0]     grant_idx;
  logic                 busy;
  logic                 lock_abort;

  modport master (
    input  req_valid, req_data, req_last, tx_done_tick,
    output req_ready, tx_start, tx_din, grant_idx, busy, lock_abort
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done_tick,
    input  req_ready, tx_start, tx_din, grant_idx, busy, lock_abort
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// uart_rr_select
//   Combinational round-robin picker. Returns the first set bit of i_req
//   scanning upward from i_ptr and wrapping modulo NREQ.
//   Ports:
//     i_req        : request vector
//     i_ptr        : scan start index (must be < NREQ)
//     o_gnt_onehot : one-hot grant (zero when nothing requested)
//     o_gnt_idx    : index of the grant (zero when nothing requested)
//     o_any        : at least one request present
// -----------------------------------------------------------------------------
module uart_rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 3
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt_onehot,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  int                w_off;
  int                w_sum;

  always_comb begin
    // Rotate so bit 0 is the requester at i_ptr; the first set bit of the
    // rotated vector is then the round-robin winner.
    w_dbl        = {i_req, i_req} >> i_ptr;
    w_rot        = w_dbl[NREQ-1:0];
    w_off        = 0;
    w_sum        = 0;
    o_any        = 1'b0;
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_off = k;
      end
    end
    if (o_any) begin
      w_sum = int'(i_ptr) + w_off;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      o_gnt_idx    = IDX_W'(w_sum);
      o_gnt_onehot = NREQ'(1) << w_sum;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx among NREQ byte-stream requesters. Round-robin choice
//   between messages; the winner keeps the transmitter until it sends a byte
//   flagged last, or until it stalls for HOLD_MAX cycles while holding it.
//   Ports:
//     clk          : system clock
//     reset_n      : synchronous active-low reset
//     bus          : requester handshakes + uart_tx controls (master side)
//     o_dbg_state  : current FSM state (arb_state_e encoding)
//     o_dbg_rr_ptr : round-robin scan start for the next free arbitration
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DBIT     = DBIT_DEFAULT,
  parameter int HOLD_MAX = 255,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.master bus,
  output logic [1:0]       o_dbg_state,
  output logic [IDX_W-1:0] o_dbg_rr_ptr
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [DBIT-1:0]       r_din;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic                  r_last;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;

  logic [NREQ-1:0]       w_grant_mask;
  logic [NREQ-1:0]       w_sel_req;
  logic [NREQ-1:0]       w_gnt_onehot;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic [DBIT-1:0]       w_sel_data;
  logic                  w_sel_last;
  logic [IDX_W-1:0]      w_grant_inc;

  logic                  w_load;
  logic                  w_hold_clr;
  logic                  w_hold_inc;
  logic                  w_rr_upd;
  logic                  w_abort;

  // In HOLD the picker only sees the locked requester, so the same
  // combinational path serves both free arbitration and locked reloads.
  assign w_grant_mask = NREQ'(1) << r_grant;

  always_comb begin
    w_sel_req = '0;
    if (r_state == S_IDLE)      w_sel_req = bus.req_valid;
    else if (r_state == S_HOLD) w_sel_req = bus.req_valid & w_grant_mask;
  end

  uart_rr_select #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .i_req        (w_sel_req),
    .i_ptr        (r_rr_ptr),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_onehot[i]) w_sel_data = bus.req_data[i*DBIT +: DBIT];
    end
  end

  assign w_sel_last  = |(bus.req_last & w_gnt_onehot);
  // Wraps at NREQ, not at 2^IDX_W.
  assign w_grant_inc = (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_hold_clr  = 1'b0;
    w_hold_inc  = 1'b0;
    w_rr_upd    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done_tick) begin
          if (r_last) begin
            w_rr_upd    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_hold_clr  = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (r_hold_cnt == HOLD_CNT_W'(HOLD_MAX - 1)) begin
          w_abort     = 1'b1;
          w_rr_upd    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_inc  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_din      <= '0;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_last     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_din   <= w_sel_data;
        r_grant <= w_gnt_idx;
        r_last  <= w_sel_last;
      end
      if (w_rr_upd) r_rr_ptr <= w_grant_inc;
      if (w_hold_clr)      r_hold_cnt <= '0;
      else if (w_hold_inc) r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
    end
  end

  // Ready and abort are masked while reset is asserted so no byte is
  // taken, and no lock drop reported, in a cycle that is being discarded.
  assign bus.req_ready  = reset_n ? w_gnt_onehot : '0;
  assign bus.lock_abort = reset_n & w_abort;
  assign bus.tx_start   = (r_state == S_LOAD);
  assign bus.tx_din     = r_din;
  assign bus.grant_idx  = r_grant;
  assign bus.busy       = (r_state != S_IDLE);

  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int DBIT     = 8;
  localparam int HOLD_MAX = 4;
  localparam int IDX_W    = 3;
  localparam int QDEPTH   = 1024;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT), .IDX_W(IDX_W)) bus ();
  logic [1:0]       dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .HOLD_MAX(HOLD_MAX), .IDX_W(IDX_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .o_dbg_state  (dbg_state),
    .o_dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // requester byte queues: {last, data}
  logic [DBIT:0]   rbuf [NREQ][QDEPTH];
  int              rhead [NREQ];
  int              rtail [NREQ];
  logic [NREQ-1:0] show;
  logic [NREQ-1:0] acc_flag;
  bit              rand_valid = 0;
  bit              rand_spur  = 0;
  int              uart_fixed = 3;
  logic            uart_done  = 1'b0;
  logic            spur_rnd   = 1'b0;
  logic            spur_dir   = 1'b0;

  assign bus.tx_done_tick = uart_done | spur_rnd | spur_dir;

  // behavioural model state
  int            m_ptr   = 0;
  int            m_grant = 0;
  int            m_owner = -1;
  int            m_idle  = 0;
  bit            m_pend  = 0;
  bit            m_send  = 0;
  bit            m_last  = 0;
  logic [DBIT-1:0] m_din = '0;

  logic [DBIT-1:0] exp_q[$];

  // event logs (cycle numbers and values)
  int              acc_cyc[$];
  int              acc_idx[$];
  int              st_cyc[$];
  int              st_idx[$];
  logic [DBIT-1:0] st_din[$];
  int              done_cyc[$];
  int              abort_cyc[$];

  int exp_order[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_fair[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  logic [7:0] exp_lock[4] = '{8'h41, 8'h42, 8'h43, 8'h00};

  // ---------------- driver tasks ----------------
  task automatic push(input int r, input logic [7:0] d, input bit l);
    rbuf[r][rtail[r]] = {l, d};
    rtail[r]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (rhead[i] != rtail[i]) return 0;
    return 1;
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_idx.delete(); st_cyc.delete(); st_idx.delete();
    st_din.delete(); done_cyc.delete(); abort_cyc.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rhead[i] = 0; rtail[i] = 0; end
    show = '0;
    clear_logs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int b;
    b = 0;
    tick();
    while (!(queues_empty() && m_owner < 0 && !m_pend && !m_send) && b < budget) begin
      tick();
      b++;
    end
    check(nm, 32'(b < budget), 32'd1);
  endtask

  task automatic wait_done(input int n, input string nm);
    int b;
    b = 0;
    while (done_cyc.size() < n && b < 100) begin tick(); b++; end
    check(nm, 32'(done_cyc.size() >= n), 32'd1);
  endtask

  // requesters: present queue heads, hold until accepted
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    show          = '0;
    for (int i = 0; i < NREQ; i++) begin rhead[i] = 0; rtail[i] = 0; end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_flag[i]) begin
          rhead[i]++;
          show[i] = 1'b0;
        end
        if (rhead[i] != rtail[i]) begin
          if (!show[i]) show[i] = rand_valid ? ($urandom_range(0, 2) == 0) : 1'b1;
        end else begin
          show[i] = 1'b0;
        end
        bus.req_valid[i]            = show[i];
        bus.req_data[i*DBIT +: DBIT] = rbuf[i][rhead[i]][DBIT-1:0];
        bus.req_last[i]             = rbuf[i][rhead[i]][DBIT];
      end
      spur_rnd = rand_spur && !m_send && ($urandom_range(0, 7) == 0);
    end
  end

  // uart_tx stand-in: done tick some cycles after each start
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1 && reset_n) begin
        d = (uart_fixed > 0) ? uart_fixed : $urandom_range(1, 6);
        repeat (d) @(posedge clk);
        #1 uart_done = 1'b1;
        @(posedge clk);
        #1 uart_done = 1'b0;
      end
    end
  end

  // ---------------- model + compare (every cycle) ----------------
  initial begin : cmp_proc
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] er;
    int              pick;
    int              j;
    bit              e_abort;
    acc_flag = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      v       = bus.req_valid;
      er      = '0;
      pick    = -1;
      e_abort = 0;
      if (reset_n && !m_pend && !m_send) begin
        if (m_owner >= 0) begin
          if (v[m_owner]) begin er[m_owner] = 1'b1; pick = m_owner; end
          else if (m_idle == HOLD_MAX - 1) e_abort = 1;
        end else begin
          for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (pick < 0 && v[j]) begin er[j] = 1'b1; pick = j; end
          end
        end
      end
      check("req_ready",  32'(bus.req_ready),  32'(er));
      check("tx_start",   32'(bus.tx_start),   32'(m_pend));
      check("busy",       32'(bus.busy),       32'(m_pend || m_send || m_owner >= 0));
      check("lock_abort", 32'(bus.lock_abort), 32'(e_abort));
      check("grant_idx",  32'(bus.grant_idx),  32'(m_grant));
      check("tx_din",     32'(bus.tx_din),     32'(m_din));
      check("rr_ptr",     32'(dbg_rr_ptr),     32'(m_ptr));

      // scoreboard: bytes leave in the order the model accepted them
      if (bus.tx_start === 1'b1) begin
        st_cyc.push_back(cyc);
        st_idx.push_back(int'(bus.grant_idx));
        st_din.push_back(bus.tx_din);
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("sb_din", 32'(bus.tx_din), 32'(exp_q.pop_front()));
      end
      acc_flag = v & bus.req_ready;
      for (int k = 0; k < NREQ; k++) if (acc_flag[k]) begin acc_cyc.push_back(cyc); acc_idx.push_back(k); end
      if (bus.tx_done_tick === 1'b1 && m_send) done_cyc.push_back(cyc);
      if (bus.lock_abort === 1'b1) abort_cyc.push_back(cyc);

      // advance the model to the next cycle
      if (!reset_n) begin
        m_ptr = 0; m_grant = 0; m_owner = -1; m_idle = 0;
        m_pend = 0; m_send = 0; m_last = 0; m_din = '0;
        exp_q.delete();
      end else if (pick >= 0) begin
        m_din   = bus.req_data[pick*DBIT +: DBIT];
        m_grant = pick;
        m_last  = bus.req_last[pick];
        m_pend  = 1;
        exp_q.push_back(m_din);
      end else if (m_pend) begin
        m_pend = 0;
        m_send = 1;
      end else if (m_send) begin
        if (bus.tx_done_tick === 1'b1) begin
          m_send = 0;
          if (m_last) begin m_owner = -1; m_ptr = (m_grant + 1) % NREQ; end
          else begin m_owner = m_grant; m_idle = 0; end
        end
      end else if (m_owner >= 0) begin
        if (e_abort) begin m_owner = -1; m_ptr = (m_grant + 1) % NREQ; end
        else m_idle++;
      end
    end
  end

  // ---------------- directed + random scenarios ----------------
  initial begin
    int total;
    int len;
    int r;

    // reset values
    apply_reset();
    tick();
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_start", 32'(bus.tx_start),  32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_din",   32'(bus.tx_din),    32'd0);
    check("rst_grant", 32'(bus.grant_idx), 32'd0);
    check("rst_ptr",   32'(dbg_rr_ptr),    32'd0);
    check("rst_abort", 32'(bus.lock_abort), 32'd0);
    check("rst_state", 32'(dbg_state),     32'd0);

    // single request from requester 2
    push(2, 8'hA5, 1'b1);
    wait_idle(100, "single_idle");
    tick();
    check("single_acc_n",   32'(acc_idx.size()), 32'd1);
    if (acc_idx.size() == 1 && st_cyc.size() == 1) begin
      check("single_acc_idx", 32'(acc_idx[0]), 32'd2);
      check("single_din",     32'(st_din[0]),  32'hA5);
      check("single_lat",     32'(st_cyc[0] - acc_cyc[0]), 32'd1);
    end
    check("single_busy", 32'(bus.busy), 32'd0);
    check("single_ptr",  32'(dbg_rr_ptr), 32'd3);

    // spurious done in IDLE
    @(posedge clk); #2 spur_dir = 1'b1;
    @(posedge clk); #2 spur_dir = 1'b0;
    tick();
    check("spur_idle_ptr",   32'(dbg_rr_ptr), 32'd3);
    check("spur_idle_state", 32'(dbg_state),  32'd0);

    // fairness
    apply_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    wait_idle(300, "fair_idle");
    check("fair_n", 32'(st_idx.size()), 32'd5);
    if (st_idx.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check("fair_order", 32'(st_idx[k]), 32'(exp_order[k]));
        check("fair_din",   32'(st_din[k]), 32'(exp_fair[k]));
      end
    end

    // locking: requester 1 message is not interleaved with requester 0
    apply_reset();
    push(0, 8'h01, 1'b1);
    wait_idle(100, "lock_pre_idle");
    clear_logs();
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    push(0, 8'h00, 1'b1);
    wait_idle(300, "lock_idle");
    check("lock_n", 32'(st_din.size()), 32'd4);
    if (st_din.size() == 4) begin
      for (int k = 0; k < 4; k++) check("lock_order", 32'(st_din[k]), 32'(exp_lock[k]));
    end

    // hold timeout
    apply_reset();
    push(3, 8'h77, 1'b0);
    wait_done(1, "hold_done_seen");
    push(0, 8'h30, 1'b1);
    wait_idle(100, "hold_idle");
    check("hold_abort_n", 32'(abort_cyc.size()), 32'd1);
    if (abort_cyc.size() == 1 && done_cyc.size() >= 1 && acc_cyc.size() == 2 && st_idx.size() == 2) begin
      check("hold_abort_cyc", 32'(abort_cyc[0] - done_cyc[0]), 32'd4);
      check("hold_next_idx",  32'(st_idx[1]), 32'd0);
      check("hold_next_din",  32'(st_din[1]), 32'h30);
      check("hold_next_acc",  32'(acc_cyc[1] - abort_cyc[0]), 32'd1);
    end

    // spurious done in HOLD
    apply_reset();
    push(2, 8'h62, 1'b0);
    wait_done(1, "spur_hold_done_seen");
    @(posedge clk); #2 spur_dir = 1'b1;
    @(posedge clk); #2 spur_dir = 1'b0;
    tick();
    check("spur_hold_state", 32'(dbg_state),  32'd3);
    check("spur_hold_ptr",   32'(dbg_rr_ptr), 32'd0);
    check("spur_hold_busy",  32'(bus.busy),   32'd1);
    wait_idle(100, "spur_hold_idle");
    tick();
    check("spur_hold_ptr_after", 32'(dbg_rr_ptr), 32'd3);

    // reset in the middle of WAIT
    apply_reset();
    push(1, 8'h99, 1'b1);
    begin
      int b;
      b = 0;
      while (st_cyc.size() < 1 && b < 50) begin tick(); b++; end
      check("rstw_start_seen", 32'(st_cyc.size()), 32'd1);
    end
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    tick();
    check("rstw_busy",  32'(bus.busy),      32'd0);
    check("rstw_din",   32'(bus.tx_din),    32'd0);
    check("rstw_grant", 32'(bus.grant_idx), 32'd0);
    check("rstw_ptr",   32'(dbg_rr_ptr),    32'd0);
    check("rstw_start", 32'(bus.tx_start),  32'd0);
    repeat (4) tick();
    check("rstw_stale_state", 32'(dbg_state), 32'd0);
    check("rstw_stale_busy",  32'(bus.busy),  32'd0);
    push(0, 8'h5A, 1'b1);
    wait_idle(100, "rstw_idle");
    check("rstw_new_n", 32'(st_din.size()), 32'd2);
    if (st_din.size() == 2) begin
      check("rstw_new_din", 32'(st_din[1]), 32'h5A);
      check("rstw_new_idx", 32'(st_idx[1]), 32'd0);
    end

    // randomized traffic against the model
    apply_reset();
    rand_valid = 1;
    rand_spur  = 1;
    uart_fixed = 0;
    total      = 0;
    for (int m = 0; m < 200; m++) begin
      r   = $urandom_range(0, NREQ - 1);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) push(r, 8'($urandom_range(0, 255)), b == len - 1);
      total += len;
    end
    wait_idle(30000, "rand_idle");
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    check("rand_bytes",    32'(st_din.size()), 32'(total));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
